// File: rtl/toy_bpu_btb_array_if.sv
// toy_bpu_btb_array_if: read/write request and read ack bundle
// between the BTB lookup/update logic and the BTB storage array.
interface toy_bpu_btb_array_if #(
  parameter int WAY_NUM     = 4,
  parameter int INDEX_WIDTH = 9,
  parameter int ENTRY_WIDTH = 64,
  parameter int NODE_WIDTH  = WAY_NUM - 1
);
  logic                           rd_req_vld;
  logic                           rd_req_rdy;
  logic [INDEX_WIDTH-1:0]         rd_req_addr;
  logic                           rd_ack_vld;
  logic [WAY_NUM*ENTRY_WIDTH-1:0] rd_ack_data;
  logic [NODE_WIDTH-1:0]          rd_ack_node;
  logic [WAY_NUM-1:0]             rd_ack_perr;
  logic                           wr_req_vld;
  logic                           wr_req_rdy;
  logic [INDEX_WIDTH-1:0]         wr_req_addr;
  logic [WAY_NUM-1:0]             wr_req_way_en;
  logic [ENTRY_WIDTH-1:0]         wr_req_data;
  logic                           wr_req_node_en;
  logic [NODE_WIDTH-1:0]          wr_req_node;

  modport master (
    output rd_req_vld, rd_req_addr,
    output wr_req_vld, wr_req_addr, wr_req_way_en,
    output wr_req_data, wr_req_node_en, wr_req_node,
    input  rd_req_rdy, wr_req_rdy,
    input  rd_ack_vld, rd_ack_data, rd_ack_node, rd_ack_perr
  );

  modport slave (
    input  rd_req_vld, rd_req_addr,
    input  wr_req_vld, wr_req_addr, wr_req_way_en,
    input  wr_req_data, wr_req_node_en, wr_req_node,
    output rd_req_rdy, wr_req_rdy,
    output rd_ack_vld, rd_ack_data, rd_ack_node, rd_ack_perr
  );
endinterface

// File: rtl/toy_bpu_btb_array.sv
// toy_bpu_btb_array: WAY_NUM-way BTB entry store plus PLRU node per set.
// Optional per-way even parity: define TOY_BPU_BTB_PARITY_EN.
module toy_bpu_btb_array #(
  parameter int WAY_NUM     = 4,
  parameter int INDEX_WIDTH = 9,
  parameter int ENTRY_WIDTH = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_req,
  output logic init_busy,
  toy_bpu_btb_array_if.slave bus
);
  localparam int NODE_WIDTH = WAY_NUM - 1;
  localparam int DEPTH = 2 ** INDEX_WIDTH;
`ifdef TOY_BPU_BTB_PARITY_EN
  localparam int SW = ENTRY_WIDTH + 1;
`else
  localparam int SW = ENTRY_WIDTH;
`endif
  localparam logic [INDEX_WIDTH:0] LAST =
    (INDEX_WIDTH+1)'(DEPTH - 1);
  localparam logic [INDEX_WIDTH:0] ONE =
    (INDEX_WIDTH+1)'(1);

  typedef enum logic {INIT, IDLE} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH:0]   cnt_q, cnt_d;

  logic [SW-1:0]          way_mem_q [WAY_NUM][DEPTH];
  logic [NODE_WIDTH-1:0]  node_mem_q [DEPTH];

  logic                   sweep;
  logic                   wr_fire;
  logic                   rd_fire;
  logic [INDEX_WIDTH-1:0] sram_addr;
  logic [WAY_NUM-1:0]     way_we;
  logic                   node_we;
  logic [SW-1:0]          way_wdata;
  logic [NODE_WIDTH-1:0]  node_wdata;
  logic                   rd_en;

  logic                   ack_vld_q;
  logic [SW-1:0]          raw_q [WAY_NUM];
  logic [NODE_WIDTH-1:0]  node_q;

  assign sweep     = rst_n && (state_q == INIT);
  assign init_busy = !rst_n || (state_q == INIT);

  assign bus.wr_req_rdy = !init_busy;
  assign bus.rd_req_rdy = !init_busy && !bus.wr_req_vld;

  assign wr_fire = bus.wr_req_vld && bus.wr_req_rdy;
  assign rd_fire = bus.rd_req_vld && bus.rd_req_rdy;

  // Sweep sequencing: clear every set once, restart on flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        if (flush_req) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      IDLE: begin
        if (flush_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Sweep state and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single shared SRAM port: sweep beats write beats read.
  always_comb begin
    sram_addr  = bus.rd_req_addr;
    way_we     = '0;
    node_we    = 1'b0;
    way_wdata  = '0;
    node_wdata = '0;
    rd_en      = 1'b0;
    if (sweep) begin
      sram_addr = cnt_q[INDEX_WIDTH-1:0];
      way_we    = '1;
      node_we   = 1'b1;
    end else if (wr_fire) begin
      sram_addr  = bus.wr_req_addr;
      way_we     = bus.wr_req_way_en;
      node_we    = bus.wr_req_node_en;
      node_wdata = bus.wr_req_node;
`ifdef TOY_BPU_BTB_PARITY_EN
      way_wdata  = {^bus.wr_req_data, bus.wr_req_data};
`else
      way_wdata  = bus.wr_req_data;
`endif
    end else if (rd_fire) begin
      rd_en = 1'b1;
    end
  end

  // SRAM macro models: way entries and PLRU nodes.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAY_NUM; w++) begin
      if (way_we[w]) way_mem_q[w][sram_addr] <= way_wdata;
    end
    if (node_we) node_mem_q[sram_addr] <= node_wdata;
  end

  // Read output register: loads only on a read, holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_vld_q <= 1'b0;
      node_q    <= '0;
      for (int w = 0; w < WAY_NUM; w++) raw_q[w] <= '0;
    end else begin
      ack_vld_q <= rd_en;
      if (rd_en) begin
        node_q <= node_mem_q[sram_addr];
        for (int w = 0; w < WAY_NUM; w++) begin
          raw_q[w] <= way_mem_q[w][sram_addr];
        end
      end
    end
  end

  // Ack data formatting; a parity-failing way is reported invalid.
  always_comb begin
    bus.rd_ack_data = '0;
`ifdef TOY_BPU_BTB_PARITY_EN
    bus.rd_ack_perr = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      bus.rd_ack_perr[w] = ^raw_q[w];
      bus.rd_ack_data[w*ENTRY_WIDTH +: ENTRY_WIDTH] =
        raw_q[w][ENTRY_WIDTH-1:0];
      if (bus.rd_ack_perr[w]) begin
        bus.rd_ack_data[w*ENTRY_WIDTH+ENTRY_WIDTH-1] = 1'b0;
      end
    end
`else
    for (int w = 0; w < WAY_NUM; w++) begin
      bus.rd_ack_data[w*ENTRY_WIDTH +: ENTRY_WIDTH] = raw_q[w];
    end
`endif
  end

`ifndef TOY_BPU_BTB_PARITY_EN
  assign bus.rd_ack_perr = '0;
`endif

  assign bus.rd_ack_vld  = ack_vld_q;
  assign bus.rd_ack_node = node_q;

endmodule

// File: doc/toy_bpu_btb_array.md
Name: toy_bpu_btb_array

Overview:
- Parametrised BTB storage array for the BPU.
- Holds WAY_NUM entry ways plus a (WAY_NUM-1)-bit PLRU node per set, all in single-port SRAM macros sharing one index.
- Adds a separate read/write request handshake, deterministic one-cycle read latency with held ack data, and a hardware clear sweep after reset or flush.
- Sits between the BTB lookup/update logic and the SRAM models, replacing the fixed-geometry array.

Parameters:
- WAY_NUM, 4: number of ways. Must be ≥2 and a power of two.
- INDEX_WIDTH, 9: set index width; depth = 2**INDEX_WIDTH.
- ENTRY_WIDTH, 64: bits per way entry. Bit ENTRY_WIDTH-1 is the entry valid bit.
- NODE_WIDTH, WAY_NUM-1: PLRU node width. Derived; do not override.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush_req  in  1  one-cycle pulse that starts a full clear sweep.
- init_busy  out  1  high while the clear sweep runs.
- rd_req_vld  in  1  read request valid.
- rd_req_rdy  out  1  read request accepted when vld&&rdy.
- rd_req_addr  in  INDEX_WIDTH  read set index.
- rd_ack_vld  out  1  read data valid; one-cycle pulse.
- rd_ack_data  out  WAY_NUM*ENTRY_WIDTH  way i at bits [i*ENTRY_WIDTH +: ENTRY_WIDTH].
- rd_ack_node  out  NODE_WIDTH  PLRU node of the read set.
- rd_ack_perr  out  WAY_NUM  per-way parity error flag.
- wr_req_vld  in  1  write request valid.
- wr_req_rdy  out  1  write request accepted when vld&&rdy.
- wr_req_addr  in  INDEX_WIDTH  write set index.
- wr_req_way_en  in  WAY_NUM  per-way write enable; any subset.
- wr_req_data  in  ENTRY_WIDTH  entry data, written to every enabled way.
- wr_req_node_en  in  1  write the PLRU node.
- wr_req_node  in  NODE_WIDTH  PLRU node write data.

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous and active-low.
- Single SRAM access per cycle. Priority: clear sweep > write > read.
- wr_req_rdy = !init_busy.
- rd_req_rdy = !init_busy && !wr_req_vld.
- A write with way_en==0 and node_en==0 is accepted as a no-op; no SRAM enable is asserted.
- Read latency is 1:
  - Read accepted in cycle N gives rd_ack_vld=1 in N+1.
  - rd_ack_data, rd_ack_node and rd_ack_perr are registered and held until the next ack.
- Write accepted in cycle N: the data is visible to a read accepted in N+1 or later. No bypass is needed because accesses are serialised.
- FSM states: INIT, IDLE.
  - Reset → INIT with sweep counter = 0.
  - INIT: each cycle, write zero to all ways and the node at the counter index, then increment the counter.
  - At counter == 2**INDEX_WIDTH-1: write that last index, then go to IDLE. INIT takes exactly 2**INDEX_WIDTH cycles.
  - IDLE + flush_req → INIT with counter = 0. A read ack already in flight is still delivered in the following cycle.
  - flush_req during INIT: counter restarts at 0.
  - rst_n low mid-sweep: sweep restarts from index 0 when rst_n goes high.
- Reset values, held while rst_n=0:
  - init_busy=1
  - rd_ack_vld=0, rd_ack_data=0, rd_ack_node=0, rd_ack_perr=0
  - rd_req_rdy=0, wr_req_rdy=0
- Counter arithmetic: unsigned INDEX_WIDTH+1 bits, so terminal detection does not wrap.

Optional Feature:
- Macro: TOY_BPU_BTB_PARITY_EN.
- Defined:
  - Each way stores ENTRY_WIDTH+1 bits; the extra bit is even parity of the entry.
  - Cleared entries store parity 0.
  - On read, a way whose recomputed parity mismatches sets rd_ack_perr[i]=1, and that way's valid bit in rd_ack_data is forced to 0.
- Not defined:
  - Ways store ENTRY_WIDTH bits.
  - rd_ack_perr is tied to 0.

Test Plan:
- Reset with INDEX_WIDTH=4: release rst_n → init_busy high for exactly 16 cycles, then 0. A read of index 5 then returns all-zero data and node.
- Write idx 3, way_en=4'b0101, data=64'hA5, node_en=1, node=3'b110. Read idx 3 next cycle → ways 0 and 2 = 64'hA5, ways 1 and 3 = 0, node=3'b110, rd_ack_vld exactly one cycle later.
- rd_req_vld and wr_req_vld asserted together → write accepted, rd_req_rdy=0. Read accepted the following cycle and returns the new data.
- flush_req at sweep index 7 of 16 → init_busy stays high 16 more cycles. Entries written before the flush read back 0.
- Hold check: read ack data stays stable across 5 idle cycles. A write to the same index does not alter the held rd_ack_data.
- TOY_BPU_BTB_PARITY_EN: force a bit flip on way 1 via a hierarchical SRAM poke, then read → rd_ack_perr=4'b0010 and the way-1 valid bit = 0.
